// File: rtl/seven_segment_arbiter.sv
// Round-robin owner selection for the shared four-digit seven-segment display.
// A minimum-hold timer limits preemption; all outputs are registered.
module seven_segment_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = 100_000_000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [16*NUM_REQ-1:0] req_data,
  input  logic [4*NUM_REQ-1:0] req_digit_en,
  input  logic [4*NUM_REQ-1:0] req_dp,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic [15:0]          disp_data,
  output logic [3:0]           disp_digit_en,
  output logic [3:0]           disp_dp
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [PW:0]   NREQ_W    = (PW+1)'(NUM_REQ);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t        state, nxt_state;
  logic [PW-1:0] ptr, nxt_ptr;
  logic [CW-1:0] hold_cnt, nxt_cnt;
  logic [NUM_REQ-1:0] nxt_grant, cand;

  logic [NUM_REQ-1:0][15:0] lane_data;
  logic [NUM_REQ-1:0][3:0]  lane_en, lane_dp;
  assign lane_data = req_data;
  assign lane_en   = req_digit_en;
  assign lane_dp   = req_dp;

  // Candidates exclude the current owner, so a pick while owned is always a switch.
  assign cand = (state == IDLE) ? req : (req & ~grant);

  logic [PW-1:0] pick;
  logic          pick_vld;
  logic [PW:0]   idx;
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = '0;
    // Reverse scan: the last hit written is the first in order from ptr.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = {1'b0, ptr} + (PW+1)'(i);
      if (idx >= NREQ_W) idx = idx - NREQ_W;
      if (cand[idx[PW-1:0]]) begin
        pick     = idx[PW-1:0];
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    logic do_grant;
    nxt_state = state;
    nxt_ptr   = ptr;
    nxt_cnt   = hold_cnt;
    nxt_grant = grant;
    do_grant  = 1'b0;
    case (state)
      IDLE: if (pick_vld) do_grant = 1'b1;
      OWNED: begin
        if ((req & grant) == '0) begin
          if (pick_vld) do_grant = 1'b1;
          else begin
            nxt_state = IDLE;
            nxt_grant = '0;
          end
        end else if (hold_cnt == '0 && pick_vld) begin
          do_grant = 1'b1;
        end else if (hold_cnt != '0) begin
          nxt_cnt = hold_cnt - 1'b1;
        end
      end
      default: begin
        nxt_state = IDLE;
        nxt_grant = '0;
      end
    endcase
    if (do_grant) begin
      nxt_state       = OWNED;
      nxt_grant       = '0;
      nxt_grant[pick] = 1'b1;
      nxt_cnt         = HOLD_LOAD;
      nxt_ptr         = (pick == PW'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
    end
  end

  logic [15:0] d_nxt;
  logic [3:0]  e_nxt, p_nxt;
  always_comb begin
    d_nxt = '0;
    e_nxt = '0;
    p_nxt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (nxt_grant[i]) begin
        d_nxt = d_nxt | lane_data[i];
        e_nxt = e_nxt | lane_en[i];
        p_nxt = p_nxt | lane_dp[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      ptr           <= '0;
      hold_cnt      <= '0;
      grant         <= '0;
      busy          <= 1'b0;
      disp_data     <= '0;
      disp_digit_en <= '0;
      disp_dp       <= '0;
    end else begin
      state         <= nxt_state;
      ptr           <= nxt_ptr;
      hold_cnt      <= nxt_cnt;
      grant         <= nxt_grant;
      busy          <= |nxt_grant;
      disp_data     <= d_nxt;
      disp_digit_en <= e_nxt;
      disp_dp       <= p_nxt;
    end
  end
endmodule

// File: tb/tb_seven_segment_arbiter.sv
// Directed bench for seven_segment_arbiter with NUM_REQ=4, HOLD_CYCLES=4.
module tb_seven_segment_arbiter;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  req = '0;
  logic [63:0] req_data = '0;
  logic [15:0] req_digit_en = '0;
  logic [15:0] req_dp = '0;
  logic [3:0]  grant;
  logic        busy;
  logic [15:0] disp_data;
  logic [3:0]  disp_digit_en;
  logic [3:0]  disp_dp;

  int checks = 0;
  int errors = 0;

  seven_segment_arbiter #(.NUM_REQ(4), .HOLD_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_data(req_data),
    .req_digit_en(req_digit_en), .req_dp(req_dp), .grant(grant), .busy(busy),
    .disp_data(disp_data), .disp_digit_en(disp_digit_en), .disp_dp(disp_dp)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n      = 1'b0;
    req          = '0;
    req_data     = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    req_digit_en = {4'b1000, 4'b0100, 4'b0010, 4'b0001};
    req_dp       = {4'b0001, 4'b0010, 4'b0100, 4'b1000};
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    reset_n = 1'b0;
    req = 4'b1111;
    step();
    step();
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_grant got %b/%b want 0000/0", grant, busy);
    end
    checks++;
    if (disp_data !== 16'h0 || disp_digit_en !== 4'h0 || disp_dp !== 4'h0) begin
      errors++; $display("FAIL reset_disp got %h/%b/%b want 0000/0000/0000", disp_data, disp_digit_en, disp_dp);
    end
    reset_n = 1'b1;
    step();
    checks++;
    if (grant !== 4'b0001 || busy !== 1'b1 || disp_data !== 16'h1111) begin
      errors++; $display("FAIL reset_first_grant got %b/%b/%h want 0001/1/1111", grant, busy, disp_data);
    end
  endtask

  task automatic test_single();
    apply_reset();
    req = 4'b0100;
    req_data[47:32] = 16'h1234;
    req_digit_en[11:8] = 4'b1111;
    req_dp[11:8] = 4'b0010;
    step();
    checks++;
    if (grant !== 4'b0100 || busy !== 1'b1) begin
      errors++; $display("FAIL single_grant got %b/%b want 0100/1", grant, busy);
    end
    checks++;
    if (disp_data !== 16'h1234 || disp_digit_en !== 4'b1111 || disp_dp !== 4'b0010) begin
      errors++; $display("FAIL single_disp got %h/%b/%b want 1234/1111/0010", disp_data, disp_digit_en, disp_dp);
    end
    req_data[47:32] = 16'hBEEF;
    step();
    checks++;
    if (disp_data !== 16'hBEEF) begin
      errors++; $display("FAIL single_live_data got %h want beef", disp_data);
    end
  endtask

  task automatic test_contention();
    logic [3:0]  exp_g;
    logic [15:0] exp_d;
    apply_reset();
    req = 4'b1001;
    for (int c = 0; c < 9; c++) begin
      step();
      exp_g = (c < 4 || c == 8) ? 4'b0001 : 4'b1000;
      exp_d = (c < 4 || c == 8) ? 16'h1111 : 16'h4444;
      checks++;
      if (grant !== exp_g || disp_data !== exp_d) begin
        errors++; $display("FAIL contention_c%0d got %b/%h want %b/%h", c, grant, disp_data, exp_g, exp_d);
      end
    end
  endtask

  task automatic test_early_release();
    apply_reset();
    req = 4'b0010;
    step();
    req = 4'b0110;
    step();
    checks++;
    if (grant !== 4'b0010) begin
      errors++; $display("FAIL early_hold got %b want 0010", grant);
    end
    req = 4'b0100;
    step();
    checks++;
    if (grant !== 4'b0100 || busy !== 1'b1 || disp_data !== 16'h3333) begin
      errors++; $display("FAIL early_switch got %b/%b/%h want 0100/1/3333", grant, busy, disp_data);
    end
  endtask

  task automatic test_lone_owner();
    int bad;
    apply_reset();
    req = 4'b0010;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (grant !== 4'b0010) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL lone_hold got %0d bad cycles want 0", bad);
    end
    req = 4'b0000;
    step();
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b0 || disp_digit_en !== 4'b0000) begin
      errors++; $display("FAIL lone_release got %b/%b/%b want 0000/0/0000", grant, busy, disp_digit_en);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    req = 4'b0001;
    step();
    req = 4'b0100;
    step();
    checks++;
    if (grant !== 4'b0100 || busy !== 1'b1) begin
      errors++; $display("FAIL handoff got %b/%b want 0100/1", grant, busy);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    req = 4'b0010;
    step();
    step();
    checks++;
    if (grant !== 4'b0010) begin
      errors++; $display("FAIL mid_owned got %b want 0010", grant);
    end
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b0 || disp_data !== 16'h0 || disp_digit_en !== 4'h0) begin
      errors++; $display("FAIL mid_async_clear got %b/%b/%h/%b want 0000/0/0000/0000", grant, busy, disp_data, disp_digit_en);
    end
    req = 4'b0110;
    step();
    reset_n = 1'b1;
    step();
    checks++;
    if (grant !== 4'b0010) begin
      errors++; $display("FAIL mid_ptr_reset got %b want 0010", grant);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_early_release();
    test_lone_owner();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seven_segment_arbiter.md
# seven_segment_arbiter

Round-robin arbiter that shares the single four-digit seven-segment display between up to `NUM_REQ` independent requesters. It sits directly in front of `SevenSegmentControl` and drives that block's `dataIn`, `digitDisplay` and `digitPoint` inputs from whichever requester currently owns the display. A minimum-hold timer stops the display from flickering between owners. All outputs are registered.

## Interface

**Parameters**

- `NUM_REQ`, default 4: number of requesters; legal range 2..8.
- `HOLD_CYCLES`, default 100_000_000: minimum ownership time in clk cycles before another requester may preempt; must be ≥ 1. The counter width is `$clog2(HOLD_CYCLES+1)`.

**Ports**

- `clk` input 1: system clock; everything is rising-edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `req` input `NUM_REQ`: level request per requester; bit i set means requester i wants the display.
- `req_data` input `16*NUM_REQ`: hex digits; requester i uses bits [16i+15:16i].
- `req_digit_en` input `4*NUM_REQ`: digit enables; requester i uses bits [4i+3:4i].
- `req_dp` input `4*NUM_REQ`: decimal points; requester i uses bits [4i+3:4i].
- `grant` output `NUM_REQ`: one-hot current owner; all zero when idle.
- `busy` output 1: high whenever any grant bit is set.
- `disp_data` output 16: connects to `SevenSegmentControl.dataIn`.
- `disp_digit_en` output 4: connects to `.digitDisplay`.
- `disp_dp` output 4: connects to `.digitPoint`.

## Operation

**Reset values**

- `grant` = 0, `busy` = 0, `disp_data` = 0, `disp_digit_en` = 0, `disp_dp` = 0.
- Internal state: `state` = IDLE, `ptr` = 0, `hold_cnt` = 0.

**Round-robin pick**

- Select the first index with `req` set, searching `ptr`, `ptr+1`, …, wrapping modulo `NUM_REQ`.
- After any grant to index k, set `ptr` = (k+1) mod `NUM_REQ`.

**IDLE**

- If `req` ≠ 0: grant the pick, load `hold_cnt` = `HOLD_CYCLES-1`, go to OWNED.
- Otherwise: stay in IDLE.

**OWNED** (owner o)

- **Release:** if `req[o]` = 0, switch at this edge.
  - If any other request is pending, grant the RR pick (which excludes o) and reload `hold_cnt`. There is no idle gap.
  - Otherwise go to IDLE with `grant` = 0.
- **Preemption:** if `req[o]` = 1, `hold_cnt` = 0, and (`req` & ~`grant`) ≠ 0, grant the RR pick and reload `hold_cnt`.
- **Hold:** in all other cases keep o.
  - Decrement `hold_cnt` while it is nonzero; it saturates at 0.
  - A lone owner keeps the display indefinitely.

**Display path**

- Each cycle, `disp_*` registers the slice selected by the next-state grant.
- This happens on the same edge as `grant`, so the display tracks live changes in the owner's data.
- In IDLE, `disp_*` = 0, which blanks all digits.

**Invariants**

- `grant` is always one-hot or zero.
- `busy` = |`grant`.
- Unused requesters never affect the outputs.

## Timing

- **Grant latency:** `req` sampled high at edge n produces `grant` at edge n+1. `disp_*` at edge n+1 holds that requester's inputs as sampled at edge n.
- **Minimum hold:** if grant arrives at edge g and a competitor is pending throughout, the owner holds for exactly `HOLD_CYCLES` cycles and the switch occurs at edge g+`HOLD_CYCLES`.
- **Early release:** `req[o]` sampled low at edge n moves the grant at edge n+1, regardless of `hold_cnt`.
- **Simultaneous requests:** when several requests arrive at once, the first in RR order from `ptr` wins.
- **Owner drops while others rise:** if the owner drops its request on the same edge a new requester rises, the new requester is granted directly.
- **Reset mid-operation:** asserting `reset_n` low forces all outputs to their reset values immediately, without waiting for a clock edge. Release is synchronous to the next edge.
  - The first grant after reset uses `ptr` = 0.

## Test plan

All scenarios use `NUM_REQ`=4 and `HOLD_CYCLES`=4.

1. **Reset:** hold `reset_n` low with `req`=4'b1111. Required: `grant`=0, `busy`=0, `disp_*`=0. After release, `grant`=4'b0001 one edge later.
2. **Single requester:** `req`=4'b0100, `req_data[47:32]`=16'h1234, en=4'b1111, dp=4'b0010. Required one edge later: `grant`=4'b0100, `disp_data`=16'h1234, `disp_digit_en`=4'b1111, `disp_dp`=4'b0010. Changing the data to 16'hBEEF appears on `disp_data` one edge later.
3. **Contention:** `req`=4'b1001 from idle with `ptr`=0. Required:
   - `grant`=4'b0001 for exactly 4 cycles, then 4'b1000 for 4 cycles, then back to 4'b0001.
   - `disp_data` alternates between the two slices in step with `grant`.
4. **Early release:** requester 1 is granted and requester 2 is pending. Drop `req[1]` on the second owned cycle. Required: `grant`=4'b0100 on the next edge, with no cycle where `grant`=0.
5. **Lone owner:** `req`=4'b0010 held for 20 cycles. Required: `grant` stays 4'b0010 throughout. Then drop `req`: `grant`=0 and `disp_digit_en`=0 on the next edge.
6. **Reset mid-ownership:** assert `reset_n` low mid-ownership, between clock edges. Required: outputs clear immediately. After release with `req`=4'b0110, `grant`=4'b0010 because `ptr` was reset to 0.
